rx_ber_checker: RTL and testbench

- Sits directly downstream of the oversampled BPSK transmit filter.
- Takes the filter's S(NB,NBF) sample stream at OS samples per baud, decimates it to one sample per baud at a selectable phase and slices each kept sample to a bit.
- Finds the bit delay against the transmitted reference bit stream, then counts bit errors and total bits for BER measurement.

---
 rtl/rx_ber_checker.sv | 155 +++++++++++++++
 tb/tb_rx_ber_checker.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_ber_checker.sv
// BER checker: decimates OS-oversampled BPSK samples, slices sign, searches reference delay, then counts errors/bits.
// Counters update 1 clock after a decision; no backpressure (i_enable low freezes state). Define BER_CLEAR_EN to add i_clear.
module rx_ber_checker #(
   parameter int NB       = 8,
   parameter int OS       = 4,
   parameter int NDELAY   = 32,
   parameter int SYNC_LEN = 128,
   parameter int NB_CNT   = 64
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      i_enable,
   input  logic                      i_valid,
   input  logic signed [NB-1:0]      i_sample,
   input  logic [$clog2(OS)-1:0]     i_phase,
   input  logic                      i_ref_valid,
   input  logic                      i_ref_bit,
`ifdef BER_CLEAR_EN
   input  logic                      i_clear,
`endif
   output logic                      o_locked,
   output logic [$clog2(NDELAY)-1:0] o_delay,
   output logic [NB_CNT-1:0]         o_err_count,
   output logic [NB_CNT-1:0]         o_bit_count
);

   localparam int PW = $clog2(OS);
   localparam int DW = $clog2(NDELAY);
   localparam int WW = $clog2(SYNC_LEN) + 1;

   typedef enum logic {SYNC, LOCKED} state_t;

   state_t              state_q, state_d;
   logic [NDELAY-1:0]   ref_sr_q, ref_sr_d;
   logic [PW-1:0]       phase_q, phase_d;
   logic [DW-1:0]       cur_delay_q, cur_delay_d;
   logic [DW-1:0]       best_delay_q, best_delay_d;
   logic [DW-1:0]       delay_q, delay_d;
   logic [WW-1:0]       best_err_q, best_err_d;
   logic [WW-1:0]       win_err_q, win_err_d;
   logic [WW-1:0]       win_cnt_q, win_cnt_d;
   logic [NB_CNT-1:0]   err_q, err_d;
   logic [NB_CNT-1:0]   bits_q, bits_d;

   logic          dec, rx_bit, mism, win_last, search_done, new_best, clr_now;
   logic [WW-1:0] win_err_sum;

   // A negative sample is a transmitted 1, i.e. the sign bit.
   assign rx_bit      = (i_sample < 0);
   assign dec         = i_enable && i_valid && (phase_q == i_phase);
   assign mism        = rx_bit ^ ref_sr_q[cur_delay_q];
   assign win_err_sum = win_err_q + WW'(mism);
   assign win_last    = dec && (state_q == SYNC) && (win_cnt_q == WW'(SYNC_LEN - 1));
   assign search_done = win_last && (cur_delay_q == DW'(NDELAY - 1));
   assign new_best    = (win_err_sum < best_err_q);

`ifdef BER_CLEAR_EN
   assign clr_now = i_enable && i_clear;
`else
   assign clr_now = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (reset) state_q <= SYNC;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (state_q == SYNC && search_done) state_d = LOCKED;
   end

   always_comb begin
      o_locked = (state_q == LOCKED);
   end

   always_comb begin
      ref_sr_d     = ref_sr_q;
      phase_d      = phase_q;
      cur_delay_d  = cur_delay_q;
      best_delay_d = best_delay_q;
      delay_d      = delay_q;
      best_err_d   = best_err_q;
      win_err_d    = win_err_q;
      win_cnt_d    = win_cnt_q;
      err_d        = err_q;
      bits_d       = bits_q;

      if (i_enable) begin
         if (i_ref_valid) ref_sr_d = {ref_sr_q[NDELAY-2:0], i_ref_bit};
         if (i_valid)     phase_d  = (phase_q == PW'(OS - 1)) ? '0 : phase_q + PW'(1);
      end

      if (dec && state_q == SYNC) begin
         if (win_last) begin
            win_cnt_d   = '0;
            win_err_d   = '0;
            cur_delay_d = cur_delay_q + DW'(1);
            if (new_best) begin
               best_err_d   = win_err_sum;
               best_delay_d = cur_delay_q;
            end
            // Strict compare above keeps the lowest delay on ties.
            if (search_done) begin
               cur_delay_d = new_best ? cur_delay_q : best_delay_q;
               delay_d     = new_best ? cur_delay_q : best_delay_q;
            end
         end else begin
            win_cnt_d = win_cnt_q + WW'(1);
            win_err_d = win_err_sum;
         end
      end

      if (state_q == LOCKED) begin
         if (clr_now) begin
            bits_d = NB_CNT'(dec);
            err_d  = NB_CNT'(dec && mism);
         end else if (dec) begin
            if (!(&bits_q))        bits_d = bits_q + NB_CNT'(1);
            if (mism && !(&err_q)) err_d  = err_q + NB_CNT'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         ref_sr_q     <= '0;
         phase_q      <= '0;
         cur_delay_q  <= '0;
         best_delay_q <= '0;
         delay_q      <= '0;
         best_err_q   <= '1;
         win_err_q    <= '0;
         win_cnt_q    <= '0;
         err_q        <= '0;
         bits_q       <= '0;
      end else begin
         ref_sr_q     <= ref_sr_d;
         phase_q      <= phase_d;
         cur_delay_q  <= cur_delay_d;
         best_delay_q <= best_delay_d;
         delay_q      <= delay_d;
         best_err_q   <= best_err_d;
         win_err_q    <= win_err_d;
         win_cnt_q    <= win_cnt_d;
         err_q        <= err_d;
         bits_q       <= bits_d;
      end
   end

   assign o_delay     = delay_q;
   assign o_err_count = err_q;
   assign o_bit_count = bits_q;

endmodule

// File: tb/tb_rx_ber_checker.sv
// Bench for rx_ber_checker: small-parameter vector table + saturation, and a default-parameter
// instance driven by PRBS9 loopback traffic checked against a behavioural model.
module tb_rx_ber_checker;

   localparam int OS = 4, NDLY = 32, SLEN = 128;

   logic              clk;
   logic              rst, en, vld, rv, rb, clr;
   logic signed [7:0] smp;
   logic [1:0]        ph;
   logic              lk;
   logic [4:0]        dly;
   logic [63:0]       ec, bc;

   logic              rst2, en2, vld2, rv2, rb2, ph2;
   logic signed [7:0] smp2;
   logic              lk2;
   logic [0:0]        dly2;
   logic [3:0]        ec2, bc2;

   int checks = 0;
   int errors = 0;

   rx_ber_checker #(.NB(8), .OS(OS), .NDELAY(NDLY), .SYNC_LEN(SLEN), .NB_CNT(64)) u_dut (
      .clock(clk), .reset(rst), .i_enable(en), .i_valid(vld), .i_sample(smp), .i_phase(ph),
      .i_ref_valid(rv), .i_ref_bit(rb),
`ifdef BER_CLEAR_EN
      .i_clear(clr),
`endif
      .o_locked(lk), .o_delay(dly), .o_err_count(ec), .o_bit_count(bc));

   rx_ber_checker #(.NB(8), .OS(2), .NDELAY(2), .SYNC_LEN(2), .NB_CNT(4)) u_small (
      .clock(clk), .reset(rst2), .i_enable(en2), .i_valid(vld2), .i_sample(smp2), .i_phase(ph2),
      .i_ref_valid(rv2), .i_ref_bit(rb2),
`ifdef BER_CLEAR_EN
      .i_clear(1'b0),
`endif
      .o_locked(lk2), .o_delay(dly2), .o_err_count(ec2), .o_bit_count(bc2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural model of the default instance ----------------
   bit              mref[$];
   int              m_nsamp, m_ndec, m_delay;
   int              m_werr[NDLY];
   bit              m_locked;
   longint unsigned m_err, m_bits;

   function automatic bit refat(int d);
      if (d < mref.size()) return mref[mref.size() - 1 - d];
      return 1'b0;
   endfunction

   task automatic m_step();
      bit dec, rx, mis, clr_now;
      int d, best;
      if (rst) begin
         mref.delete();
         m_nsamp = 0; m_ndec = 0; m_delay = 0; m_locked = 0; m_err = 0; m_bits = 0;
         foreach (m_werr[i]) m_werr[i] = 0;
         return;
      end
      if (!en) return;
      dec = vld && ((m_nsamp % OS) == int'(ph));
      rx  = (smp < 0);
      if (m_locked) begin
         mis = dec && (rx != refat(m_delay));
         clr_now = 1'b0;
`ifdef BER_CLEAR_EN
         clr_now = clr;
`endif
         if (clr_now) begin
            m_bits = dec; m_err = mis;
         end else if (dec) begin
            if (m_bits != 64'hFFFF_FFFF_FFFF_FFFF) m_bits++;
            if (mis && m_err != 64'hFFFF_FFFF_FFFF_FFFF) m_err++;
         end
      end else if (dec) begin
         d = m_ndec / SLEN;
         m_werr[d] += (rx != refat(d)) ? 1 : 0;
         m_ndec++;
         if (m_ndec == NDLY * SLEN) begin
            best = 0;
            for (int i = 1; i < NDLY; i++) if (m_werr[i] < m_werr[best]) best = i;
            m_locked = 1'b1;
            m_delay  = best;
         end
      end
      if (vld) m_nsamp++;
      if (rv) mref.push_back(rb);
   endtask

   // ---------------- helpers ----------------
   task automatic step();
      m_step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_model(input string nm);
      chk({nm, ".locked"}, lk, m_locked);
      chk({nm, ".delay"},  dly, m_delay);
      chk({nm, ".err"},    ec, m_err);
      chk({nm, ".bits"},   bc, m_bits);
   endtask

   function automatic logic signed [7:0] mk_sample(input bit neg);
      int mag;
      mag = int'($urandom_range(127, 1));
      return neg ? 8'(-mag) : 8'(mag);
   endfunction

   logic [8:0] prbs = 9'h1FF;
   bit         txh[$];

   // One baud: OS samples carrying the reference bit sent 6 bauds earlier (ref_sr index 5).
   task automatic baud(input bit flip, input bit gap, input bit clr_dec, input bit chk_lock);
      int idx;
      bit sym, nb;
      idx = txh.size() - 6;
      sym = (idx >= 0) ? txh[idx] : 1'b0;
      nb  = prbs[8] ^ prbs[4];
      prbs = {prbs[7:0], nb};
      for (int s = 0; s < OS; s++) begin
         en = 1; vld = 1; smp = mk_sample(sym ^ flip);
         rv = (s == OS - 1); rb = nb;
         clr = clr_dec && (s == int'(ph));
         step();
         if (chk_lock && s == 0) chk("lock_rise", lk, 1);
         if (gap) begin
            vld = 0; rv = 0; clr = 0;
            step();
         end
      end
      vld = 0; rv = 0; clr = 0;
      txh.push_back(nb);
   endtask

   typedef struct {
      bit en, vld, neg, ph, rv, rb;
      bit e_lk, e_dly;
      int e_err, e_bit;
   } vec_t;

   vec_t tbl[16];

   initial begin
      tbl[0]  = '{1,1,0,1,1,1, 0,0,0,0};
      tbl[1]  = '{1,1,1,1,1,0, 0,0,0,0};
      tbl[2]  = '{1,1,0,1,0,0, 0,0,0,0};
      tbl[3]  = '{1,1,1,1,1,1, 0,0,0,0};
      tbl[4]  = '{1,0,0,1,0,0, 0,0,0,0};
      tbl[5]  = '{1,1,0,1,1,1, 0,0,0,0};
      tbl[6]  = '{1,1,1,1,1,0, 0,0,0,0};
      tbl[7]  = '{0,1,0,1,1,1, 0,0,0,0};
      tbl[8]  = '{1,1,0,1,0,0, 0,0,0,0};
      tbl[9]  = '{1,1,1,1,0,0, 1,1,0,0};
      tbl[10] = '{1,1,0,1,0,0, 1,1,0,0};
      tbl[11] = '{1,1,0,1,1,0, 1,1,1,1};
      tbl[12] = '{1,1,1,1,0,0, 1,1,1,1};
      tbl[13] = '{1,1,0,1,0,0, 1,1,1,2};
      tbl[14] = '{1,1,1,0,0,0, 1,1,2,3};
      tbl[15] = '{1,1,1,0,0,0, 1,1,2,3};

      rst = 1; en = 0; vld = 0; smp = 0; ph = 0; rv = 0; rb = 0; clr = 0;
      rst2 = 1; en2 = 0; vld2 = 0; smp2 = 0; ph2 = 0; rv2 = 0; rb2 = 0;
      step(); step();
      chk("rst.locked", lk, 0); chk("rst.delay", dly, 0); chk("rst.err", ec, 0); chk("rst.bits", bc, 0);
      chk("rst2.locked", lk2, 0); chk("rst2.err", ec2, 0); chk("rst2.bits", bc2, 0);
      rst = 0; rst2 = 0;

      // Small instance: cycle-by-cycle vectors through search, lock and counting.
      for (int i = 0; i < 16; i++) begin
         en2 = tbl[i].en; vld2 = tbl[i].vld; smp2 = tbl[i].neg ? -8'sd64 : 8'sd64;
         ph2 = tbl[i].ph; rv2 = tbl[i].rv; rb2 = tbl[i].rb;
         step();
         chk($sformatf("tbl%0d.locked", i), lk2, tbl[i].e_lk);
         chk($sformatf("tbl%0d.delay", i), dly2, tbl[i].e_dly);
         chk($sformatf("tbl%0d.err", i), ec2, tbl[i].e_err);
         chk($sformatf("tbl%0d.bits", i), bc2, tbl[i].e_bit);
      end

      // Saturation: every decision is an error; 4-bit counters stop at 15.
      en2 = 1; vld2 = 1; ph2 = 0; rv2 = 0; smp2 = -8'sd64;
      for (int i = 0; i < 24; i++) step();
      chk("sat.mid_bits", bc2, 15);
      chk("sat.mid_err", ec2, 14);
      for (int i = 0; i < 16; i++) step();
      chk("sat.bits", bc2, 15);
      chk("sat.err", ec2, 15);
      chk("sat.locked", lk2, 1);
      rst2 = 1; step(); rst2 = 0; en2 = 0; vld2 = 0;
      chk("rst2_locked.locked", lk2, 0); chk("rst2_locked.delay", dly2, 0);
      chk("rst2_locked.err", ec2, 0); chk("rst2_locked.bits", bc2, 0);

      // Ideal loopback at phase 0.
      ph = 0;
      for (int k = 0; k < NDLY * SLEN - 1; k++) baud(0, 0, 0, 0);
      chk("pre_lock", lk, 0);
      baud(0, 0, 0, 1);
      chk("lock.delay", dly, 5);
      chk_model("lock");
      for (int k = 0; k < 1000; k++) baud(0, 0, 0, 0);
      chk("ideal.bits", bc, 1000);
      chk("ideal.err", ec, 0);
      chk_model("ideal");

      // Error injection: one flipped baud in every 100.
      for (int k = 0; k < 1000; k++) baud(k % 100 == 99, 0, 0, 0);
      chk("inject.bits", bc, 2000);
      chk("inject.err", ec, 10);
      chk_model("inject");

      // Phase 2, valid every other cycle, random errors, enable stall in the middle.
      ph = 2;
      for (int k = 0; k < 100; k++) baud($urandom_range(9, 0) == 0, 1, 0, 0);
      chk("phase.bits", bc, 2100);
      chk_model("phase");
      for (int i = 0; i < 50; i++) begin
         en = 0; vld = 1'($urandom); rv = 1'($urandom); rb = 1'($urandom); smp = 8'($urandom);
         step();
      end
      en = 1; vld = 0; rv = 0;
      chk("stall.bits", bc, 2100);
      chk_model("stall");
      for (int k = 0; k < 100; k++) baud($urandom_range(9, 0) == 0, 1, 0, 0);
      chk("phase2.bits", bc, 2200);
      chk_model("phase2");

`ifdef BER_CLEAR_EN
      baud(1, 0, 1, 0);
      chk("clear.bits", bc, 1);
      chk("clear.err", ec, 1);
      chk_model("clear");
`endif

      // Reset from LOCKED, reset again mid-search, then relock.
      ph = 0;
      rst = 1; step(); rst = 0;
      chk("rst_lk.locked", lk, 0); chk("rst_lk.err", ec, 0); chk("rst_lk.bits", bc, 0);
      for (int k = 0; k < 2000; k++) baud(0, 0, k == 100, 0);
      chk("sync.locked", lk, 0); chk("sync.err", ec, 0); chk("sync.bits", bc, 0);
      rst = 1; step(); rst = 0;
      chk("rst_sync.locked", lk, 0); chk("rst_sync.delay", dly, 0);
      for (int k = 0; k < NDLY * SLEN - 1; k++) baud(0, 0, k == 300, 0);
      chk("relock.pre", lk, 0);
      baud(0, 0, 0, 1);
      chk("relock.delay", dly, 5);
      for (int k = 0; k < 50; k++) baud(k == 20, 0, 0, 0);
      chk("relock.bits", bc, 50);
      chk("relock.err", ec, 1);
      chk_model("relock");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
